// File: rtl/prco_exec_unit_if.sv
// PRCO execute-unit bus: decode/ALU strobes and operands in,
// decoded fields, strobes, ALU result and IO outputs back.
interface prco_exec_unit_if;
    logic        i_dec_ce;
    logic [15:0] i_instr;
    logic        i_alu_ce;
    logic [15:0] i_data;
    logic [15:0] i_datb;

    logic [5:0]  q_op;
    logic [2:0]  q_seld;
    logic [2:0]  q_sela;
    logic [2:0]  q_selb;
    logic [15:0] q_imm8;
    logic [4:0]  q_simm5;
    logic        q_dec_ce;
    logic        q_fetch;
    logic        q_reg_we;
    logic        q_req_ram;
    logic        q_req_ram_we;
    logic        q_halt;
    logic [15:0] q_result;
    logic        q_ce_ram;
    logic        q_ce_reg;
    logic        q_should_branch;
    logic [7:0]  q_uart1_tx_data;
    logic        q_uart1_new;
    logic [7:0]  q_gpio1;

    modport slave (
        input  i_dec_ce, i_instr, i_alu_ce, i_data, i_datb,
        output q_op, q_seld, q_sela, q_selb, q_imm8, q_simm5,
        output q_dec_ce, q_fetch, q_reg_we, q_req_ram,
        output q_req_ram_we, q_halt,
        output q_result, q_ce_ram, q_ce_reg, q_should_branch,
        output q_uart1_tx_data, q_uart1_new, q_gpio1
    );

    modport master (
        output i_dec_ce, i_instr, i_alu_ce, i_data, i_datb,
        input  q_op, q_seld, q_sela, q_selb, q_imm8, q_simm5,
        input  q_dec_ce, q_fetch, q_reg_we, q_req_ram,
        input  q_req_ram_we, q_halt,
        input  q_result, q_ce_ram, q_ce_reg, q_should_branch,
        input  q_uart1_tx_data, q_uart1_new, q_gpio1
    );
endinterface

// File: rtl/prco_exec_unit.sv
// PRCO decode + ALU + UART/GPIO output stage.
// Ports: i_clk, i_reset (sync, active high), bus (slave side).
module prco_exec_unit #(
    parameter logic [7:0] GPIO_RST = 8'h00
) (
    input  logic i_clk,
    input  logic i_reset,
    prco_exec_unit_if.slave bus
);
    localparam logic [5:0] OP_MOV  = 6'h01;
    localparam logic [5:0] OP_MOVI = 6'h02;
    localparam logic [5:0] OP_ADD  = 6'h03;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_SUB  = 6'h05;
    localparam logic [5:0] OP_AND  = 6'h06;
    localparam logic [5:0] OP_OR   = 6'h07;
    localparam logic [5:0] OP_XOR  = 6'h08;
    localparam logic [5:0] OP_SHL  = 6'h09;
    localparam logic [5:0] OP_SHR  = 6'h0A;
    localparam logic [5:0] OP_CMP  = 6'h0B;
    localparam logic [5:0] OP_JMP  = 6'h0C;
    localparam logic [5:0] OP_JE   = 6'h0D;
    localparam logic [5:0] OP_JNE  = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h0F;
    localparam logic [5:0] OP_SW   = 6'h10;
    localparam logic [5:0] OP_UART = 6'h11;
    localparam logic [5:0] OP_GPIO = 6'h12;
    localparam logic [5:0] OP_HALT = 6'h1F;

    logic        flag_z, flag_n, flag_c;
    logic        uart_pend, gpio_pend;

    logic [5:0]  dec_op;
    logic [15:0] sx5;
    logic [16:0] wide;
    logic [15:0] res, fval;
    logic        c_nxt, fl_we, br;

    assign dec_op = {1'b0, bus.i_instr[15:11]};
    assign sx5    = {{11{bus.q_simm5[4]}}, bus.q_simm5};

    // Combinational ALU on the registered decode; NOP/CMP/HALT
    // and undefined opcodes keep the old result.
    always_comb begin
        wide  = 17'd0;
        res   = bus.q_result;
        c_nxt = 1'b0;
        fl_we = 1'b0;
        br    = 1'b0;
        case (bus.q_op)
            OP_MOV:  res = bus.i_datb;
            OP_MOVI: res = bus.q_imm8;
            OP_ADD: begin
                wide  = {1'b0, bus.i_data} + {1'b0, bus.i_datb};
                res   = wide[15:0];
                c_nxt = wide[16];
                fl_we = 1'b1;
            end
            OP_ADDI: begin
                wide  = {1'b0, bus.i_data} + {1'b0, sx5};
                res   = wide[15:0];
                c_nxt = wide[16];
                fl_we = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // bit 16 of the widened difference is the borrow
                wide  = {1'b0, bus.i_data} - {1'b0, bus.i_datb};
                c_nxt = wide[16];
                fl_we = 1'b1;
                if (bus.q_op == OP_SUB)
                    res = wide[15:0];
            end
            OP_AND: begin
                res   = bus.i_data & bus.i_datb;
                fl_we = 1'b1;
            end
            OP_OR: begin
                res   = bus.i_data | bus.i_datb;
                fl_we = 1'b1;
            end
            OP_XOR: begin
                res   = bus.i_data ^ bus.i_datb;
                fl_we = 1'b1;
            end
            OP_SHL: begin
                res   = bus.i_data << bus.i_datb[3:0];
                fl_we = 1'b1;
            end
            OP_SHR: begin
                res   = bus.i_data >> bus.i_datb[3:0];
                fl_we = 1'b1;
            end
            OP_JMP: begin
                res = bus.q_imm8;
                br  = 1'b1;
            end
            OP_JE: begin
                res = bus.q_imm8;
                br  = flag_z;
            end
            OP_JNE: begin
                res = bus.q_imm8;
                br  = ~flag_z;
            end
            OP_LW, OP_SW:     res = bus.i_datb + sx5;
            OP_UART, OP_GPIO: res = bus.i_data;
            default: ;
        endcase
    end

    // CMP sets flags from the difference without writing the result
    assign fval = (bus.q_op == OP_CMP) ? wide[15:0] : res;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bus.q_op            <= '0;
            bus.q_seld          <= '0;
            bus.q_sela          <= '0;
            bus.q_selb          <= '0;
            bus.q_imm8          <= '0;
            bus.q_simm5         <= '0;
            bus.q_dec_ce        <= 1'b0;
            bus.q_fetch         <= 1'b0;
            bus.q_reg_we        <= 1'b0;
            bus.q_req_ram       <= 1'b0;
            bus.q_req_ram_we    <= 1'b0;
            bus.q_halt          <= 1'b0;
            bus.q_result        <= '0;
            bus.q_ce_ram        <= 1'b0;
            bus.q_ce_reg        <= 1'b0;
            bus.q_should_branch <= 1'b0;
            bus.q_uart1_tx_data <= '0;
            bus.q_uart1_new     <= 1'b0;
            bus.q_gpio1         <= GPIO_RST;
            flag_z              <= 1'b0;
            flag_n              <= 1'b0;
            flag_c              <= 1'b0;
            uart_pend           <= 1'b0;
            gpio_pend           <= 1'b0;
        end else begin
            bus.q_dec_ce        <= 1'b0;
            bus.q_fetch         <= 1'b0;
            bus.q_ce_ram        <= 1'b0;
            bus.q_ce_reg        <= 1'b0;
            bus.q_should_branch <= 1'b0;
            bus.q_uart1_new     <= 1'b0;
            uart_pend           <= 1'b0;
            gpio_pend           <= 1'b0;

            if (uart_pend) begin
                bus.q_uart1_tx_data <= bus.q_result[7:0];
                bus.q_uart1_new     <= 1'b1;
            end
            if (gpio_pend)
                bus.q_gpio1 <= bus.q_result[7:0];

            if (!bus.q_halt && bus.i_alu_ce) begin
                bus.q_result <= res;
                if (bus.q_req_ram) begin
                    bus.q_ce_ram <= 1'b1;
                end else begin
                    bus.q_ce_reg        <= 1'b1;
                    bus.q_should_branch <= br;
                end
                if (fl_we) begin
                    flag_z <= (fval == 16'd0);
                    flag_n <= fval[15];
                    flag_c <= c_nxt;
                end
                uart_pend <= (bus.q_op == OP_UART);
                gpio_pend <= (bus.q_op == OP_GPIO);
            end

            if (!bus.q_halt && bus.i_dec_ce) begin
                bus.q_op     <= dec_op;
                bus.q_seld   <= bus.i_instr[10:8];
                bus.q_sela   <= bus.i_instr[7:5];
                bus.q_selb   <= bus.i_instr[4:2];
                bus.q_imm8   <= {{8{bus.i_instr[7]}}, bus.i_instr[7:0]};
                bus.q_simm5  <= bus.i_instr[4:0];
                bus.q_reg_we <= (dec_op >= OP_MOV && dec_op <= OP_SHR)
                                || dec_op == OP_LW;
                bus.q_req_ram    <= (dec_op == OP_LW) || (dec_op == OP_SW);
                bus.q_req_ram_we <= (dec_op == OP_SW);
                if (dec_op == OP_HALT)
                    bus.q_halt <= 1'b1;
                else if (dec_op >= OP_MOV && dec_op <= OP_GPIO)
                    bus.q_dec_ce <= 1'b1;
                else
                    bus.q_fetch <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_prco_exec_unit.sv
// Directed bench for prco_exec_unit: opcode-level model checked
// every cycle, plus literal checks on key scenarios.
module tb_prco_exec_unit;
    localparam logic [7:0] GRST = 8'h3C;

    logic clk;
    logic rst;
    prco_exec_unit_if bus ();

    prco_exec_unit #(.GPIO_RST(GRST)) dut (
        .i_clk  (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit live  = 1'b0;

    // model state
    logic [5:0]  e_op;
    logic [2:0]  e_seld, e_sela, e_selb;
    logic [15:0] e_imm;
    logic [4:0]  e_simm5;
    logic        e_dec_ce, e_fetch, e_reg_we, e_req_ram, e_req_we;
    logic        e_halt, e_ce_ram, e_ce_reg, e_br, e_new;
    logic [15:0] e_res;
    logic [7:0]  e_tx, e_gpio;
    logic        e_z, e_n, e_c;
    bit          c_valid, p_uart, p_gpio;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic m_alu(input int d, input int a);
        int r, fv, sx;
        bit br, hold, fl, cv, c;
        r = int'(e_res); fv = 0; br = 0; hold = 0; fl = 0;
        cv = 0; c = 0;
        sx = int'($signed(e_simm5));
        case (int'(e_op))
            1:  r = a;
            2:  r = int'(e_imm);
            3:  begin r = d + a; c = r > 65535; cv = 1; fl = 1; end
            4:  begin r = d + (sx & 'hFFFF); c = r > 65535;
                      cv = 1; fl = 1; end
            5:  begin r = d - a; c = d < a; cv = 1; fl = 1; end
            6:  begin r = d & a; fl = 1; end
            7:  begin r = d | a; fl = 1; end
            8:  begin r = d ^ a; fl = 1; end
            9:  begin r = d << (a % 16); fl = 1; end
            10: begin r = d >> (a % 16); fl = 1; end
            11: begin fv = d - a; c = d < a; cv = 1; fl = 1;
                      hold = 1; end
            12: begin r = int'(e_imm); br = 1; end
            13: begin r = int'(e_imm); br = e_z; end
            14: begin r = int'(e_imm); br = !e_z; end
            15, 16: r = a + sx;
            17, 18: r = d;
            default: hold = 1;
        endcase
        if (!hold) fv = r;
        if (!hold) e_res = 16'(r);
        if (fl) begin
            e_z = (16'(fv) == 16'd0);
            e_n = fv[15];
            e_c = c;
            c_valid = cv;
        end
        e_ce_ram = e_req_ram;
        e_ce_reg = !e_req_ram;
        e_br     = br && !e_req_ram;
        p_uart   = (e_op == 6'h11);
        p_gpio   = (e_op == 6'h12);
    endtask

    task automatic m_dec(input logic [15:0] ins);
        int op;
        op = int'(ins[15:11]);
        e_op    = 6'(op);
        e_seld  = ins[10:8];
        e_sela  = ins[7:5];
        e_selb  = ins[4:2];
        e_imm   = 16'($signed(ins[7:0]));
        e_simm5 = ins[4:0];
        e_reg_we  = (op >= 1 && op <= 10) || op == 15;
        e_req_ram = (op == 15 || op == 16);
        e_req_we  = (op == 16);
        if (op == 31) e_halt = 1;
        else if (op >= 1 && op <= 18) e_dec_ce = 1;
        else e_fetch = 1;
    endtask

    task automatic step(input bit dec, input logic [15:0] ins,
                        input bit alu, input logic [15:0] d,
                        input logic [15:0] b, input bit r);
        bit pu, pg;
        rst = r;
        bus.i_dec_ce = dec; bus.i_instr = ins;
        bus.i_alu_ce = alu; bus.i_data = d; bus.i_datb = b;
        @(posedge clk);
        e_dec_ce = 0; e_fetch = 0; e_ce_ram = 0; e_ce_reg = 0;
        e_br = 0; e_new = 0;
        if (r) begin
            e_op = 0; e_seld = 0; e_sela = 0; e_selb = 0; e_imm = 0;
            e_simm5 = 0; e_reg_we = 0; e_req_ram = 0; e_req_we = 0;
            e_halt = 0; e_res = 0; e_tx = 0; e_gpio = GRST;
            e_z = 0; e_n = 0; e_c = 0; c_valid = 1;
            p_uart = 0; p_gpio = 0; live = 1;
        end else begin
            pu = p_uart; pg = p_gpio;
            p_uart = 0; p_gpio = 0;
            if (pu) begin e_tx = e_res[7:0]; e_new = 1; end
            if (pg) e_gpio = e_res[7:0];
            if (!e_halt && alu) m_alu(int'(d), int'(b));
            if (!e_halt && dec) m_dec(ins);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 16'h0, 0, 16'h0, 16'h0, 0);
    endtask
    task automatic dec(input logic [15:0] ins);
        step(1, ins, 0, 16'h0, 16'h0, 0);
    endtask
    task automatic alu(input logic [15:0] d, input logic [15:0] b);
        step(0, 16'h0, 1, d, b, 0);
    endtask
    task automatic op(input logic [15:0] ins, input logic [15:0] d,
                      input logic [15:0] b);
        dec(ins);
        alu(d, b);
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("op",     16'(bus.q_op),     16'(e_op));
            chk("seld",   16'(bus.q_seld),   16'(e_seld));
            chk("sela",   16'(bus.q_sela),   16'(e_sela));
            chk("selb",   16'(bus.q_selb),   16'(e_selb));
            chk("imm8",   bus.q_imm8,        e_imm);
            chk("simm5",  16'(bus.q_simm5),  16'(e_simm5));
            chk("dec_ce", 16'(bus.q_dec_ce), 16'(e_dec_ce));
            chk("fetch",  16'(bus.q_fetch),  16'(e_fetch));
            chk("reg_we", 16'(bus.q_reg_we), 16'(e_reg_we));
            chk("req_ram", 16'(bus.q_req_ram), 16'(e_req_ram));
            chk("req_we", 16'(bus.q_req_ram_we), 16'(e_req_we));
            chk("halt",   16'(bus.q_halt),   16'(e_halt));
            chk("result", bus.q_result,      e_res);
            chk("ce_ram", 16'(bus.q_ce_ram), 16'(e_ce_ram));
            chk("ce_reg", 16'(bus.q_ce_reg), 16'(e_ce_reg));
            chk("branch", 16'(bus.q_should_branch), 16'(e_br));
            chk("tx",     16'(bus.q_uart1_tx_data), 16'(e_tx));
            chk("new",    16'(bus.q_uart1_new), 16'(e_new));
            chk("gpio",   16'(bus.q_gpio1),  16'(e_gpio));
            chk("flag_z", 16'(dut.flag_z),   16'(e_z));
            chk("flag_n", 16'(dut.flag_n),   16'(e_n));
            if (c_valid)
                chk("flag_c", 16'(dut.flag_c), 16'(e_c));
        end
    end

    initial begin
        step(0, 16'h0, 0, 16'h0, 16'h0, 1);
        step(0, 16'h0, 0, 16'h0, 16'h0, 1);
        chk("rst_gpio", 16'(bus.q_gpio1), 16'h003C);
        chk("rst_result", bus.q_result, 16'h0000);

        // ADD r2,r2: 7FFF + 1
        dec(16'h1A48);
        chk("add_dec_ce", 16'(bus.q_dec_ce), 16'h1);
        alu(16'h7FFF, 16'h0001);
        chk("add_res", bus.q_result, 16'h8000);
        chk("add_ce_reg", 16'(bus.q_ce_reg), 16'h1);
        chk("add_nzc", {13'b0, dut.flag_n, dut.flag_z, dut.flag_c},
            16'h0004);

        // SUB 5-5 then JE 0x20
        op({5'h05, 3'd1, 3'd2, 5'd0}, 16'h0005, 16'h0005);
        op({5'h0D, 3'd0, 8'h20}, 16'h0, 16'h0);
        chk("je_br", 16'(bus.q_should_branch), 16'h1);
        chk("je_res", bus.q_result, 16'h0020);
        op({5'h05, 3'd1, 3'd2, 5'd0}, 16'h0005, 16'h0005);
        op({5'h0E, 3'd0, 8'h20}, 16'h0, 16'h0);
        chk("jne_br", 16'(bus.q_should_branch), 16'h0);
        op({5'h0C, 3'd0, 8'hF0}, 16'h0, 16'h0);

        // LW / SW with negative offset
        op({5'h0F, 3'd1, 3'd0, 5'h1F}, 16'h1234, 16'h0010);
        chk("lw_res", bus.q_result, 16'h000F);
        chk("lw_ce_ram", 16'(bus.q_ce_ram), 16'h1);
        chk("lw_ce_reg", 16'(bus.q_ce_reg), 16'h0);
        chk("lw_reg_we", 16'(bus.q_reg_we), 16'h1);
        op({5'h10, 3'd2, 3'd3, 5'h02}, 16'h0, 16'hFFFF);

        // UART then GPIO
        op({5'h11, 11'h0}, 16'h1241, 16'h0);
        idle();
        chk("uart_tx", 16'(bus.q_uart1_tx_data), 16'h0041);
        chk("uart_new", 16'(bus.q_uart1_new), 16'h1);
        idle();
        chk("uart_new_off", 16'(bus.q_uart1_new), 16'h0);
        op({5'h12, 11'h0}, 16'h00A5, 16'h0);
        idle();
        chk("gpio", 16'(bus.q_gpio1), 16'h00A5);

        // remaining ALU ops and flag corners
        op({5'h04, 3'd1, 3'd0, 5'h1F}, 16'h0003, 16'h0);
        op({5'h03, 11'h0}, 16'hFFFF, 16'h0001);
        chk("add_wrap", bus.q_result, 16'h0000);
        op({5'h06, 11'h0}, 16'hF0F0, 16'h3C3C);
        op({5'h07, 11'h0}, 16'hF0F0, 16'h0F01);
        op({5'h08, 11'h0}, 16'hAAAA, 16'hFFFF);
        op({5'h09, 11'h0}, 16'h0003, 16'h0014);
        op({5'h0A, 11'h0}, 16'h8000, 16'h000F);
        op({5'h0B, 11'h0}, 16'h0003, 16'h0005);
        chk("cmp_hold", bus.q_result, 16'h0001);
        op({5'h02, 3'd4, 8'h80}, 16'h0, 16'h0);
        chk("movi", bus.q_result, 16'hFF80);

        // second decode overrides first
        dec({5'h02, 3'd1, 8'h11});
        dec({5'h01, 3'd1, 3'd2, 5'd0});
        alu(16'h0000, 16'hBEEF);
        chk("redec", bus.q_result, 16'hBEEF);

        // NOP and undefined opcode
        dec(16'h0000);
        chk("nop_fetch", 16'(bus.q_fetch), 16'h1);
        chk("nop_dec_ce", 16'(bus.q_dec_ce), 16'h0);
        alu(16'h1111, 16'h2222);
        op({5'h13, 11'h0}, 16'h0, 16'h0);

        // reset beats a simultaneous alu strobe
        dec(16'h1A48);
        step(0, 16'h0, 1, 16'h0001, 16'h0001, 1);
        idle();
        chk("rst_ce_reg", 16'(bus.q_ce_reg), 16'h0);

        // HALT is sticky until reset
        dec(16'hF800);
        chk("halt", 16'(bus.q_halt), 16'h1);
        op(16'h1A48, 16'h0001, 16'h0001);
        chk("halt_ce", 16'(bus.q_ce_reg), 16'h0);
        idle();
        step(0, 16'h0, 0, 16'h0, 16'h0, 1);
        chk("unhalt", 16'(bus.q_halt), 16'h0);
        chk("unhalt_gpio", 16'(bus.q_gpio1), 16'h003C);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
